addsub16_seq: RTL

Multi-cycle 16-bit signed add/subtract controller that sequences a single shared 4-bit nibble adder over four clock cycles, least-significant nibble first, with a registered carry between nibbles. It sits beside the ALU as the area-reduced add/sub path: a start/done handshake launches an operation and reports the result, so the datapath avoids a full-width carry chain.

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/addsub_nibble.sv | 30 +++
 rtl/addsub16_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
// Optional feature macro: ADDSUB16_SEQ_SAT_EN (saturating result on signed overflow).
package addsub_pkg;

    // Controller states: waiting, stepping through nibbles, reporting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the shared adder slice.
    localparam int NIB_W = 4;

    // Widest result the saturation helper can describe.
    localparam int SAT_MAX_W = 64;

    // Saturation value for a signed WIDTH-bit result: most negative when
    // 'negative' is set, otherwise most positive. The caller truncates to width.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic negative);
        logic [SAT_MAX_W-1:0] msb;
        msb = 64'd1 << (width - 1);
        return negative ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit ripple adder slice. Exposes the carry into the top bit
// so the controller can derive signed overflow from the most significant nibble.
module addsub_nibble
    import addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    // carry[i] is the carry into bit i; carry[NIB_W] is the carry out.
    logic [NIB_W:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NIB_W; gi++) begin : g_bit
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c3   = carry[NIB_W-1];
    assign cout = carry[NIB_W];

endmodule

// File: rtl/addsub16_seq.sv
// Nibble-serial signed add/subtract controller. One shared 4-bit adder is
// stepped over the operands LSB nibble first, with a registered carry.
// Latency from accepted start to done pulse is WIDTH/4 + 1 cycles.
// Optional feature macro: ADDSUB16_SEQ_SAT_EN clamps the result on overflow.
// WIDTH must be a multiple of 4.
module addsub16_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl
);

    localparam int N     = WIDTH / NIB_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef ADDSUB16_SEQ_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_value(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_value(WIDTH, 1'b1));
`endif

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               sub_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               ovfl_reg;
    logic               done_reg;

    logic               accept;
    logic               last_nib;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_s;
    logic               nib_cout;
    logic               nib_c3;
    logic               nib_ovf;

    // A new operation is taken whenever the adder is not mid-sequence.
    assign accept   = start && (state_reg != RUN);
    assign last_nib = (idx_reg == IDX_W'(N - 1));

    // Subtraction is A + ~B + 1: invert B here, the +1 comes from the seeded carry.
    assign nib_a   = a_reg[idx_reg*NIB_W +: NIB_W];
    assign nib_b   = b_reg[idx_reg*NIB_W +: NIB_W] ^ {NIB_W{sub_reg}};
    assign nib_ovf = nib_c3 ^ nib_cout;

    addsub_nibble u_nibble (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .s    (nib_s),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DONE may hand straight over to a new RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_nib ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy covers exactly the nibble-stepping cycles.
    always_comb begin
        busy = (state_reg == RUN);
    end

    // Datapath: operand capture, nibble write-back, carry/index and result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            ovfl_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (accept) begin
                a_reg     <= A;
                b_reg     <= B;
                sub_reg   <= sub;
                carry_reg <= sub;
                idx_reg   <= '0;
            end else if (state_reg == RUN) begin
                sum_reg[idx_reg*NIB_W +: NIB_W] <= nib_s;
                carry_reg <= nib_cout;
                idx_reg   <= idx_reg + IDX_W'(1);
                if (last_nib) begin
                    ovfl_reg <= nib_ovf;
`ifdef ADDSUB16_SEQ_SAT_EN
                    // Wrapped MSB set means the true result was positive, and vice versa.
                    if (nib_ovf) begin
                        sum_reg <= nib_s[NIB_W-1] ? SAT_POS : SAT_NEG;
                    end
`endif
                end
            end
        end
    end

    assign done = done_reg;
    assign Sum  = sum_reg;
    assign Ovfl = ovfl_reg;

endmodule
